// File: rtl/bgpu_pkg.sv
// Shared types for the GPU execution-unit stages.
// Holds the integer-unit opcode enum and constants used across stages.
package bgpu_pkg;

   // Only two-operand instructions reach the integer unit.
   localparam int unsigned IuOperands = 2;

   typedef enum logic [3:0] {
      IuAdd  = 4'd0,
      IuSub  = 4'd1,
      IuAnd  = 4'd2,
      IuOr   = 4'd3,
      IuXor  = 4'd4,
      IuSll  = 4'd5,
      IuSrl  = 4'd6,
      IuSra  = 4'd7,
      IuSltu = 4'd8,
      IuSlt  = 4'd9
   } iu_op_t;

endpackage

// File: rtl/integer_lane.sv
// Single-lane combinational integer ALU.
// Ports:
//   op_i  - operation
//   a_i   - operand A
//   b_i   - operand B (only its low log2(RegWidth) bits are the shift amount)
//   act_i - lane active; an inactive lane outputs zero
//   res_o - result, modulo 2^RegWidth
module integer_lane
   import bgpu_pkg::*;
#(
   parameter int unsigned RegWidth = 32
) (
   input  iu_op_t              op_i,
   input  logic [RegWidth-1:0] a_i,
   input  logic [RegWidth-1:0] b_i,
   input  logic                act_i,
   output logic [RegWidth-1:0] res_o
);

   localparam int unsigned ShWidth = $clog2(RegWidth);

   logic [ShWidth-1:0]  shamt;
   logic [RegWidth-1:0] res;

   assign shamt = b_i[ShWidth-1:0];

   always_comb begin
      res = '0;
      case (op_i)
         IuAdd:  res = a_i + b_i;
         IuSub:  res = a_i - b_i;
         IuAnd:  res = a_i & b_i;
         IuOr:   res = a_i | b_i;
         IuXor:  res = a_i ^ b_i;
         IuSll:  res = a_i << shamt;
         IuSrl:  res = a_i >> shamt;
         IuSra:  res = $signed(a_i) >>> shamt;
         IuSltu: res = {{(RegWidth-1){1'b0}}, (a_i < b_i)};
         IuSlt:  res = {{(RegWidth-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         // Undefined encodings yield zero.
         default: res = '0;
      endcase
   end

   assign res_o = act_i ? res : '0;

endmodule

// File: rtl/integer_unit.sv
// Two-stage pipelined integer execution unit for a warp of lanes.
// S1 captures the accepted instruction; S2 holds the computed result.
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   opc_valid_i/eu_ready_o  - accept handshake from the operand collector
//   opc_tag_i, opc_op_i, opc_act_mask_i, opc_dst_i, opc_operands_i - instruction
//   eu_valid_o/opc_ready_i  - result handshake towards writeback
//   eu_tag_o, eu_dst_o, eu_act_mask_o, eu_data_o - result
//   busy_o                  - an instruction is in flight
module integer_unit
   import bgpu_pkg::*;
#(
   parameter int unsigned NumTags         = 8,
   parameter int unsigned NumWarps        = 8,
   parameter int unsigned WarpWidth       = 4,
   parameter int unsigned RegIdxWidth     = 8,
   parameter int unsigned RegWidth        = 32,
   parameter int unsigned OperandsPerInst = 2,
   localparam int unsigned IidWidth       = $clog2(NumWarps) + $clog2(NumTags),
   localparam int unsigned RegDataWidth   = RegWidth * WarpWidth
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic                                      opc_valid_i,
   output logic                                      eu_ready_o,
   input  logic [IidWidth-1:0]                       opc_tag_i,
   input  iu_op_t                                    opc_op_i,
   input  logic [WarpWidth-1:0]                      opc_act_mask_i,
   input  logic [RegIdxWidth-1:0]                    opc_dst_i,
   input  logic [OperandsPerInst-1:0][RegDataWidth-1:0] opc_operands_i,
   output logic                                      eu_valid_o,
   input  logic                                      opc_ready_i,
   output logic [IidWidth-1:0]                       eu_tag_o,
   output logic [RegIdxWidth-1:0]                    eu_dst_o,
   output logic [WarpWidth-1:0]                      eu_act_mask_o,
   output logic [RegDataWidth-1:0]                   eu_data_o,
   output logic                                      busy_o
);

   if (OperandsPerInst != IuOperands) begin : gen_bad_operands
      $fatal(1, "integer_unit: OperandsPerInst must be 2");
   end

   // S1: captured instruction
   logic                    s1_valid_q, s1_valid_d;
   iu_op_t                  s1_op_q, s1_op_d;
   logic [IidWidth-1:0]     s1_tag_q, s1_tag_d;
   logic [RegIdxWidth-1:0]  s1_dst_q, s1_dst_d;
   logic [WarpWidth-1:0]    s1_mask_q, s1_mask_d;
   logic [RegDataWidth-1:0] s1_a_q, s1_a_d;
   logic [RegDataWidth-1:0] s1_b_q, s1_b_d;

   // S2: result
   logic                    s2_valid_q, s2_valid_d;
   logic [IidWidth-1:0]     s2_tag_q, s2_tag_d;
   logic [RegIdxWidth-1:0]  s2_dst_q, s2_dst_d;
   logic [WarpWidth-1:0]    s2_mask_q, s2_mask_d;
   logic [RegDataWidth-1:0] s2_data_q, s2_data_d;

   logic [RegDataWidth-1:0] alu_res;
   logic                    s2_free;
   logic                    s1_move;

   for (genvar g = 0; g < WarpWidth; g++) begin : gen_lane
      integer_lane #(
         .RegWidth (RegWidth)
      ) u_lane (
         .op_i  (s1_op_q),
         .a_i   (s1_a_q[g*RegWidth +: RegWidth]),
         .b_i   (s1_b_q[g*RegWidth +: RegWidth]),
         .act_i (s1_mask_q[g]),
         .res_o (alu_res[g*RegWidth +: RegWidth])
      );
   end

   // S2 can take a new entry if empty or its result leaves this cycle.
   assign s2_free    = !s2_valid_q || opc_ready_i;
   assign s1_move    = s1_valid_q && s2_free;
   assign eu_ready_o = !s1_valid_q || s1_move;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_tag_d   = s1_tag_q;
      s1_dst_d   = s1_dst_q;
      s1_mask_d  = s1_mask_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      s2_tag_d   = s2_tag_q;
      s2_dst_d   = s2_dst_q;
      s2_mask_d  = s2_mask_q;
      s2_data_d  = s2_data_q;

      if (eu_ready_o) begin
         s1_valid_d = opc_valid_i;
         if (opc_valid_i) begin
            s1_op_d   = opc_op_i;
            s1_tag_d  = opc_tag_i;
            s1_dst_d  = opc_dst_i;
            s1_mask_d = opc_act_mask_i;
            s1_a_d    = opc_operands_i[0];
            s1_b_d    = opc_operands_i[1];
         end
      end

      if (s2_free) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_tag_d  = s1_tag_q;
            s2_dst_d  = s1_dst_q;
            s2_mask_d = s1_mask_q;
            s2_data_d = alu_res;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   // Payload is qualified by the valid bits, so it is not reset.
   always_ff @(posedge clk_i) begin
      s1_op_q   <= s1_op_d;
      s1_tag_q  <= s1_tag_d;
      s1_dst_q  <= s1_dst_d;
      s1_mask_q <= s1_mask_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s2_tag_q  <= s2_tag_d;
      s2_dst_q  <= s2_dst_d;
      s2_mask_q <= s2_mask_d;
      s2_data_q <= s2_data_d;
   end

   assign eu_valid_o    = s2_valid_q;
   assign eu_tag_o      = s2_tag_q;
   assign eu_dst_o      = s2_dst_q;
   assign eu_act_mask_o = s2_mask_q;
   assign eu_data_o     = s2_data_q;
   assign busy_o        = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_integer_unit.sv
// Scoreboard bench for integer_unit (WarpWidth=4, RegWidth=32).
module tb_integer_unit;
   import bgpu_pkg::*;

   localparam int unsigned IidW = 6;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               opc_valid_i;
   logic               eu_ready_o;
   logic [IidW-1:0]    opc_tag_i;
   iu_op_t             opc_op_i;
   logic [3:0]         opc_act_mask_i;
   logic [7:0]         opc_dst_i;
   logic [1:0][127:0]  opc_operands_i;
   logic               eu_valid_o;
   logic               opc_ready_i;
   logic [IidW-1:0]    eu_tag_o;
   logic [7:0]         eu_dst_o;
   logic [3:0]         eu_act_mask_o;
   logic [127:0]       eu_data_o;
   logic               busy_o;

   integer_unit u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .opc_valid_i    (opc_valid_i),
      .eu_ready_o     (eu_ready_o),
      .opc_tag_i      (opc_tag_i),
      .opc_op_i       (opc_op_i),
      .opc_act_mask_i (opc_act_mask_i),
      .opc_dst_i      (opc_dst_i),
      .opc_operands_i (opc_operands_i),
      .eu_valid_o     (eu_valid_o),
      .opc_ready_i    (opc_ready_i),
      .eu_tag_o       (eu_tag_o),
      .eu_dst_o       (eu_dst_o),
      .eu_act_mask_o  (eu_act_mask_o),
      .eu_data_o      (eu_data_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [IidW-1:0] tag;
      logic [7:0]      dst;
      logic [3:0]      mask;
      logic [127:0]    data;
      int              acc;
      bit              lat;
   } exp_t;

   exp_t         sb[$];
   int           n_vec = 0;
   int           n_mis = 0;
   int           cyc   = 0;
   bit           stall_prev = 1'b0;
   logic [146:0] prev_out;
   bit           use_const = 1'b0;
   bit           chk_lat   = 1'b0;
   logic [127:0] const_exp;

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [127:0] model(input logic [3:0] op, input logic [127:0] a,
                                          input logic [127:0] b, input logic [3:0] m);
      logic [127:0] r;
      logic [31:0]  x, y, z;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         x = a[i*32 +: 32];
         y = b[i*32 +: 32];
         case (op)
            4'd0: z = x + y;
            4'd1: z = x - y;
            4'd2: z = x & y;
            4'd3: z = x | y;
            4'd4: z = x ^ y;
            4'd5: z = x << y[4:0];
            4'd6: z = x >> y[4:0];
            4'd7: z = $unsigned($signed(x) >>> y[4:0]);
            4'd8: z = (x < y) ? 32'd1 : 32'd0;
            4'd9: z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: z = 32'd0;
         endcase
         if (m[i]) r[i*32 +: 32] = z;
      end
      return r;
   endfunction

   // Called just after a rising edge with inputs already driven.
   task automatic step(output bit acc);
      exp_t         e;
      logic [146:0] cur;
      #1;
      acc = 1'b0;
      cur = {eu_valid_o, eu_tag_o, eu_dst_o, eu_act_mask_o, eu_data_o};
      if (rst_i) begin
         sb.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) check("stall_hold", 160'(cur), 160'(prev_out));
         if (eu_valid_o && opc_ready_i) begin
            if (sb.size() == 0) begin
               check("spurious_result", 160'(eu_tag_o), 160'(1'b0) - 1);
            end else begin
               e = sb.pop_front();
               check("tag", 160'(eu_tag_o), 160'(e.tag));
               check("dst", 160'(eu_dst_o), 160'(e.dst));
               check("mask", 160'(eu_act_mask_o), 160'(e.mask));
               check("data", 160'(eu_data_o), 160'(e.data));
               if (e.lat) check("latency", 160'(cyc - e.acc), 160'(2));
            end
         end
         if (opc_valid_i && eu_ready_o) begin
            e.tag  = opc_tag_i;
            e.dst  = opc_dst_i;
            e.mask = opc_act_mask_i;
            e.data = use_const ? const_exp
                   : model(opc_op_i, opc_operands_i[0], opc_operands_i[1], opc_act_mask_i);
            e.acc  = cyc;
            e.lat  = chk_lat;
            sb.push_back(e);
            acc = 1'b1;
         end
         stall_prev = eu_valid_o && !opc_ready_i;
         prev_out   = cur;
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [3:0] op, input logic [127:0] a, input logic [127:0] b,
                       input logic [3:0] m, input logic [IidW-1:0] tag, input bit cst,
                       input logic [127:0] exp);
      bit acc;
      opc_valid_i       = 1'b1;
      opc_op_i          = iu_op_t'(op);
      opc_operands_i[0] = a;
      opc_operands_i[1] = b;
      opc_act_mask_i    = m;
      opc_tag_i         = tag;
      opc_dst_i         = 8'(tag) + 8'h40;
      use_const         = cst;
      chk_lat           = cst && (sb.size() == 0) && !busy_o;
      const_exp         = exp;
      acc               = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) step(acc);
      if (!acc) check("accept_timeout", 160'(acc), 160'(1));
      opc_valid_i = 1'b0;
      use_const   = 1'b0;
      chk_lat     = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      opc_valid_i = 1'b0;
      opc_ready_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step(acc);
         if (sb.size() == 0 && !busy_o && i >= 3) break;
      end
      check("drain_empty", 160'(sb.size()), 160'(0));
   endtask

   initial begin
      bit acc;
      rst_i          = 1'b1;
      opc_valid_i    = 1'b0;
      opc_ready_i    = 1'b1;
      opc_tag_i      = '0;
      opc_op_i       = IuAdd;
      opc_act_mask_i = '0;
      opc_dst_i      = '0;
      opc_operands_i = '0;
      @(posedge clk_i);
      #1;
      step(acc);
      rst_i = 1'b0;
      check("rst_valid", 160'(eu_valid_o), 160'(0));
      check("rst_busy", 160'(busy_o), 160'(0));
      check("rst_ready", 160'(eu_ready_o), 160'(1));

      // Directed vectors with fixed expectations.
      send(4'd1, {32'd1, 32'd7, 32'd0, 32'd5}, {32'd2, 32'd7, 32'd1, 32'd3}, 4'hF, 6'd1, 1'b1,
           {32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'd2});
      drain();
      send(4'd7, {4{32'h80000000}}, {4{32'h21}}, 4'hF, 6'd2, 1'b1, {4{32'hC0000000}});
      drain();
      send(4'd9, {4{32'hFFFFFFFF}}, {4{32'h1}}, 4'hF, 6'd3, 1'b1, {4{32'h1}});
      drain();
      send(4'd8, {4{32'hFFFFFFFF}}, {4{32'h1}}, 4'hF, 6'd4, 1'b1, {4{32'h0}});
      drain();
      send(4'd0, {4{32'h1}}, {4{32'h1}}, 4'b0101, 6'd5, 1'b1, {32'h0, 32'd2, 32'h0, 32'd2});
      drain();
      send(4'd5, {4{32'h1}}, {4{32'hFFFFFFE4}}, 4'hF, 6'd6, 1'b1, {4{32'h10}});
      drain();
      send(4'd12, {4{32'h1234}}, {4{32'h5678}}, 4'hF, 6'd7, 1'b1, 128'h0);
      drain();
      send(4'd0, {4{32'h3}}, {4{32'h4}}, 4'h0, 6'd8, 1'b1, 128'h0);
      drain();

      // Back-to-back with writeback stalled for three cycles.
      opc_ready_i = 1'b0;
      send(4'd0, {4{32'd10}}, {4{32'd1}}, 4'hF, 6'd1, 1'b0, '0);
      send(4'd0, {4{32'd20}}, {4{32'd2}}, 4'hF, 6'd2, 1'b0, '0);
      opc_valid_i = 1'b1;
      opc_tag_i   = 6'd3;
      opc_dst_i   = 8'h43;
      step(acc);
      check("b2b_ready_low", 160'(acc), 160'(0));
      opc_ready_i = 1'b1;
      step(acc);
      check("b2b_third_accept", 160'(acc), 160'(1));
      drain();

      // Reset with two instructions in flight.
      opc_ready_i = 1'b0;
      send(4'd0, {4{32'd1}}, {4{32'd1}}, 4'hF, 6'd9, 1'b0, '0);
      send(4'd0, {4{32'd2}}, {4{32'd2}}, 4'hF, 6'd10, 1'b0, '0);
      rst_i = 1'b1;
      step(acc);
      rst_i = 1'b0;
      check("midrst_valid", 160'(eu_valid_o), 160'(0));
      check("midrst_busy", 160'(busy_o), 160'(0));
      check("midrst_ready", 160'(eu_ready_o), 160'(1));
      drain();

      // Random traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         opc_valid_i       = ($urandom_range(3) != 0);
         opc_op_i          = iu_op_t'(4'($urandom_range(11)));
         opc_operands_i[0] = {$urandom, $urandom, $urandom, $urandom};
         opc_operands_i[1] = {$urandom, $urandom, $urandom, $urandom};
         opc_act_mask_i    = 4'($urandom);
         opc_tag_i         = 6'($urandom);
         opc_dst_i         = 8'($urandom);
         opc_ready_i       = ($urandom_range(2) != 0);
         step(acc);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
